grant_lock_arbiter: RTL

GRANT_LOCK_ARBITER -- requirements
Module: mprcGrantLockArbiter

---
 rtl/grant_lock_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/grant_lock_arbiter.sv
// Two-requester grant channel arbiter that holds the channel for the full
// four beats of a multibeat grant. Define GRANT_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module grant_lock_arbiter (
    input  logic         clk,
    input  logic         reset,

    input  logic         io_in_0_valid,
    output logic         io_in_0_ready,
    input  logic [1:0]   io_in_0_bits_addr_beat,
    input  logic [1:0]   io_in_0_bits_client_xact_id,
    input  logic [3:0]   io_in_0_bits_manager_xact_id,
    input  logic         io_in_0_bits_is_builtin_type,
    input  logic [3:0]   io_in_0_bits_g_type,
    input  logic [127:0] io_in_0_bits_data,

    input  logic         io_in_1_valid,
    output logic         io_in_1_ready,
    input  logic [1:0]   io_in_1_bits_addr_beat,
    input  logic [1:0]   io_in_1_bits_client_xact_id,
    input  logic [3:0]   io_in_1_bits_manager_xact_id,
    input  logic         io_in_1_bits_is_builtin_type,
    input  logic [3:0]   io_in_1_bits_g_type,
    input  logic [127:0] io_in_1_bits_data,

    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [1:0]   io_out_bits_addr_beat,
    output logic [1:0]   io_out_bits_client_xact_id,
    output logic [3:0]   io_out_bits_manager_xact_id,
    output logic         io_out_bits_is_builtin_type,
    output logic [3:0]   io_out_bits_g_type,
    output logic [127:0] io_out_bits_data,

    output logic         io_chosen,
    output logic         io_locked
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] beat_cnt_r;
    logic [1:0] beat_cnt_nxt_s;
    logic       lock_idx_r;
    logic       lock_idx_nxt_s;
    logic       arb_idx_s;
    logic       chosen_s;
    logic       out_valid_s;
    logic       fire_s;

    // Builtin GrantData (4) and non-builtin Data (1) carry a full cache line.
    function automatic logic is_multibeat(input logic builtin, input logic [3:0] g_type);
        return (builtin && (g_type == 4'h4)) || (!builtin && (g_type == 4'h1));
    endfunction

`ifdef GRANT_ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Round-robin winner among valid inputs while unlocked.
    always_comb begin
        arb_idx_s = 1'b0;
        if (io_in_0_valid && io_in_1_valid) begin
            arb_idx_s = ~last_grant_r;
        end else if (io_in_1_valid) begin
            arb_idx_s = 1'b1;
        end else if (io_in_0_valid) begin
            arb_idx_s = 1'b0;
        end else begin
            arb_idx_s = ~last_grant_r;
        end
    end

    // Last-grant history advances only on beats accepted while unlocked.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (fire_s && (state_r == ST_IDLE)) begin
            last_grant_r <= chosen_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed-priority winner while unlocked: input 0 first.
    always_comb begin
        arb_idx_s = 1'b0;
        if (io_in_0_valid) begin
            arb_idx_s = 1'b0;
        end else if (io_in_1_valid) begin
            arb_idx_s = 1'b1;
        end else begin
            arb_idx_s = 1'b0;
        end
    end
`endif

    // Select the driving requester and form the accepted-beat strobe.
    always_comb begin
        chosen_s = 1'b0;
        if (reset) begin
            chosen_s = 1'b0;
        end else if (state_r == ST_LOCKED) begin
            chosen_s = lock_idx_r;
        end else begin
            chosen_s = arb_idx_s;
        end
        out_valid_s = (!reset) && (chosen_s ? io_in_1_valid : io_in_0_valid);
        fire_s      = out_valid_s && io_out_ready;
    end

    // State, beat counter and lock index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 2'd0;
            lock_idx_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
        end
    end

    // Next-state logic; nothing moves without an accepted output beat.
    always_comb begin
        state_nxt_s    = state_r;
        beat_cnt_nxt_s = beat_cnt_r;
        lock_idx_nxt_s = lock_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s && is_multibeat(io_out_bits_is_builtin_type, io_out_bits_g_type)) begin
                    state_nxt_s    = ST_LOCKED;
                    beat_cnt_nxt_s = 2'd1;
                    lock_idx_nxt_s = chosen_s;
                end else begin
                    state_nxt_s    = ST_IDLE;
                    beat_cnt_nxt_s = 2'd0;
                end
            end
            ST_LOCKED: begin
                if (fire_s && (beat_cnt_r == 2'd3)) begin
                    state_nxt_s    = ST_IDLE;
                    beat_cnt_nxt_s = 2'd0;
                end else if (fire_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + 2'd1;
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                beat_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Output logic: unregistered flow-through of the chosen requester.
    always_comb begin
        io_out_valid  = out_valid_s;
        io_chosen     = chosen_s;
        io_locked     = (!reset) && (state_r == ST_LOCKED);
        io_in_0_ready = (!reset) && (chosen_s == 1'b0) && io_out_ready;
        io_in_1_ready = (!reset) && (chosen_s == 1'b1) && io_out_ready;
        if (chosen_s) begin
            io_out_bits_addr_beat       = io_in_1_bits_addr_beat;
            io_out_bits_client_xact_id  = io_in_1_bits_client_xact_id;
            io_out_bits_manager_xact_id = io_in_1_bits_manager_xact_id;
            io_out_bits_is_builtin_type = io_in_1_bits_is_builtin_type;
            io_out_bits_g_type          = io_in_1_bits_g_type;
            io_out_bits_data            = io_in_1_bits_data;
        end else begin
            io_out_bits_addr_beat       = io_in_0_bits_addr_beat;
            io_out_bits_client_xact_id  = io_in_0_bits_client_xact_id;
            io_out_bits_manager_xact_id = io_in_0_bits_manager_xact_id;
            io_out_bits_is_builtin_type = io_in_0_bits_is_builtin_type;
            io_out_bits_g_type          = io_in_0_bits_g_type;
            io_out_bits_data            = io_in_0_bits_data;
        end
    end

endmodule
